// File: rtl/kronos_arb_pkg.sv
// ============================================================================
// kronos_arb_pkg : shared types for the Kronos multi-core memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package kronos_arb_pkg;

  typedef enum logic {
    CLS_DATA  = 1'b0,
    CLS_INSTR = 1'b1
  } req_class_e;

  // Core index field is sized for the maximum supported core count
  localparam int unsigned TAG_IDX_W = $clog2(8);

  typedef struct packed {
    logic                 valid;
    req_class_e           cls;
    logic [TAG_IDX_W-1:0] idx;
    logic                 is_write;
  } arb_tag_t;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

endpackage

`default_nettype wire

// File: rtl/kronos_rr_picker.sv
// ============================================================================
// kronos_rr_picker : combinational requester picker, fixed-priority or
//                    round-robin starting at ptr
// Rev 1.0
// ============================================================================
`default_nettype none

module kronos_rr_picker
  import kronos_arb_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          mode,
  output logic          gnt_valid,
  output logic [PW-1:0] gnt_idx
);

  logic [PW-1:0] start;
  logic          hi_hit;
  logic          lo_hit;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;

  assign start = (mode == ARB_RR) ? ptr : '0;

  // Lowest index at/after start wins; otherwise wrap to the lowest index overall
  always_comb begin
    hi_hit = 1'b0;
    lo_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int c = N - 1; c >= 0; c--) begin
      if (req[c]) begin
        lo_hit = 1'b1;
        lo_idx = PW'(c);
        if (PW'(c) >= start) begin
          hi_hit = 1'b1;
          hi_idx = PW'(c);
        end
      end
    end
  end

  assign gnt_valid = lo_hit;
  assign gnt_idx   = hi_hit ? hi_idx : lo_idx;

endmodule

`default_nettype wire

// File: rtl/kronos_mem_arbiter.sv
// ============================================================================
// kronos_mem_arbiter : shares one single-port SRAM between the instruction and
//                      data ports of NUM_CORES Kronos cores
// Rev 1.0
// ============================================================================
`default_nettype none

module kronos_mem_arbiter
  import kronos_arb_pkg::*;
#(
  parameter int unsigned NUM_CORES    = 2,
  parameter int unsigned ARB_MODE     = 1,
  parameter int unsigned MEM_LATENCY  = 1,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        rstz,
  input  logic [NUM_CORES-1:0][31:0]  instr_addr,
  input  logic [NUM_CORES-1:0]        instr_req,
  output logic [NUM_CORES-1:0][31:0]  instr_data,
  output logic [NUM_CORES-1:0]        instr_ack,
  input  logic [NUM_CORES-1:0][31:0]  data_addr,
  input  logic [NUM_CORES-1:0][31:0]  data_wr_data,
  input  logic [NUM_CORES-1:0][3:0]   data_mask,
  input  logic [NUM_CORES-1:0]        data_wr_en,
  input  logic [NUM_CORES-1:0]        data_req,
  output logic [NUM_CORES-1:0][31:0]  data_rd_data,
  output logic [NUM_CORES-1:0]        data_ack,
  output logic                        mem_en,
  output logic                        mem_wr_en,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wr_data,
  output logic [3:0]                  mem_mask,
  input  logic [31:0]                 mem_rd_data
);

  localparam int unsigned       PTR_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned       CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(NUM_CORES - 1);
  localparam logic              MODE_SEL = (ARB_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_tag_t             tag_q [MEM_LATENCY];
  arb_tag_t             tag_d;
  arb_tag_t             head;
  logic [PTR_W-1:0]     instr_ptr_q, instr_ptr_d;
  logic [PTR_W-1:0]     data_ptr_q, data_ptr_d;
  logic [CNT_W-1:0]     starve_q, starve_d;
  logic [NUM_CORES-1:0] instr_busy, data_busy;
  logic [NUM_CORES-1:0] instr_elig, data_elig;
  logic                 instr_hit, data_hit;
  logic [PTR_W-1:0]     instr_win, data_win, win_idx;
  logic                 gnt_instr, gnt_data, starve_force;

  // A requester with any tag in the pipeline (including the acking head) is busy
  always_comb begin
    instr_busy = '0;
    data_busy  = '0;
    for (int s = 0; s < MEM_LATENCY; s++) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        if (tag_q[s].valid && (tag_q[s].idx == TAG_IDX_W'(c))) begin
          if (tag_q[s].cls == CLS_INSTR) instr_busy[c] = 1'b1;
          else                           data_busy[c]  = 1'b1;
        end
      end
    end
  end

  assign instr_elig = instr_req & ~instr_busy;
  assign data_elig  = data_req & ~data_busy;

  kronos_rr_picker #(.N(NUM_CORES), .PW(PTR_W)) u_pick_instr (
    .req       (instr_elig),
    .ptr       (instr_ptr_q),
    .mode      (MODE_SEL),
    .gnt_valid (instr_hit),
    .gnt_idx   (instr_win)
  );

  kronos_rr_picker #(.N(NUM_CORES), .PW(PTR_W)) u_pick_data (
    .req       (data_elig),
    .ptr       (data_ptr_q),
    .mode      (MODE_SEL),
    .gnt_valid (data_hit),
    .gnt_idx   (data_win)
  );

  // Data outranks instr unless instr has lost STARVE_LIMIT times in a row
  assign starve_force = (starve_q == CNT_MAX);
  assign gnt_instr    = rstz & instr_hit & (starve_force | ~data_hit);
  assign gnt_data     = rstz & data_hit & ~gnt_instr;
  assign win_idx      = gnt_instr ? instr_win : data_win;

  always_comb begin
    mem_en      = gnt_instr | gnt_data;
    mem_wr_en   = 1'b0;
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_mask    = '0;
    if (gnt_instr) begin
      mem_addr = instr_addr[instr_win];
    end else if (gnt_data) begin
      mem_addr  = data_addr[data_win];
      mem_wr_en = data_wr_en[data_win];
      if (data_wr_en[data_win]) begin
        mem_wr_data = data_wr_data[data_win];
        mem_mask    = data_mask[data_win];
      end
    end
  end

  always_comb begin
    tag_d          = '0;
    tag_d.valid    = gnt_instr | gnt_data;
    tag_d.cls      = gnt_instr ? CLS_INSTR : CLS_DATA;
    tag_d.idx      = TAG_IDX_W'(win_idx);
    tag_d.is_write = gnt_data & data_wr_en[data_win];
  end

  always_comb begin
    instr_ptr_d = instr_ptr_q;
    data_ptr_d  = data_ptr_q;
    if (gnt_instr) instr_ptr_d = (instr_win == PTR_LAST) ? '0 : instr_win + 1'b1;
    if (gnt_data)  data_ptr_d  = (data_win == PTR_LAST) ? '0 : data_win + 1'b1;
  end

  always_comb begin
    starve_d = starve_q;
    if (gnt_instr || !instr_hit) begin
      starve_d = '0;
    end else if (gnt_data && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      for (int s = 0; s < MEM_LATENCY; s++) tag_q[s] <= '0;
      instr_ptr_q <= '0;
      data_ptr_q  <= '0;
      starve_q    <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int s = 1; s < MEM_LATENCY; s++) tag_q[s] <= tag_q[s-1];
      instr_ptr_q <= instr_ptr_d;
      data_ptr_q  <= data_ptr_d;
      starve_q    <= starve_d;
    end
  end

  assign head = tag_q[MEM_LATENCY-1];

  always_comb begin
    instr_ack    = '0;
    instr_data   = '0;
    data_ack     = '0;
    data_rd_data = '0;
    for (int c = 0; c < NUM_CORES; c++) begin
      if (head.valid && (head.idx == TAG_IDX_W'(c))) begin
        if (head.cls == CLS_INSTR) begin
          instr_ack[c]  = 1'b1;
          instr_data[c] = mem_rd_data;
        end else begin
          data_ack[c] = 1'b1;
          if (!head.is_write) data_rd_data[c] = mem_rd_data;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_kronos_mem_arbiter.sv
// ============================================================================
// tb_kronos_mem_arbiter : directed bench, instance A (RR, LAT1, STARVE 3) and
//                         instance B (fixed, LAT2, STARVE 8) on shared stimulus
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_kronos_mem_arbiter;

  localparam int N = 2;

  logic clk = 1'b0;
  logic rstz;
  logic [N-1:0][31:0] instr_addr, data_addr, data_wr_data;
  logic [N-1:0][3:0]  data_mask;
  logic [N-1:0]       instr_req, data_req, data_wr_en;

  logic [N-1:0][31:0] a_instr_data, a_data_rd, b_instr_data, b_data_rd;
  logic [N-1:0]       a_instr_ack, a_data_ack, b_instr_ack, b_data_ack;
  logic               a_mem_en, a_mem_we, b_mem_en, b_mem_we;
  logic [31:0]        a_mem_addr, a_mem_wd, b_mem_addr, b_mem_wd;
  logic [3:0]         a_mem_mask, b_mem_mask;
  logic [31:0]        a_rd_q, b_rd_q1, b_rd_q2;

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic        pl_en = 1'b0;
  logic [31:0] pl_addr, pl_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kronos_mem_arbiter #(.NUM_CORES(N), .ARB_MODE(1), .MEM_LATENCY(1), .STARVE_LIMIT(3)) u_dut_a (
    .clk(clk), .rstz(rstz),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_data(a_instr_data), .instr_ack(a_instr_ack),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask), .data_wr_en(data_wr_en),
    .data_req(data_req), .data_rd_data(a_data_rd), .data_ack(a_data_ack),
    .mem_en(a_mem_en), .mem_wr_en(a_mem_we), .mem_addr(a_mem_addr), .mem_wr_data(a_mem_wd),
    .mem_mask(a_mem_mask), .mem_rd_data(a_rd_q)
  );

  kronos_mem_arbiter #(.NUM_CORES(N), .ARB_MODE(0), .MEM_LATENCY(2), .STARVE_LIMIT(8)) u_dut_b (
    .clk(clk), .rstz(rstz),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_data(b_instr_data), .instr_ack(b_instr_ack),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask), .data_wr_en(data_wr_en),
    .data_req(data_req), .data_rd_data(b_data_rd), .data_ack(b_data_ack),
    .mem_en(b_mem_en), .mem_wr_en(b_mem_we), .mem_addr(b_mem_addr), .mem_wr_data(b_mem_wd),
    .mem_mask(b_mem_mask), .mem_rd_data(b_rd_q2)
  );

  // SRAM models: A returns data one cycle after grant, B two cycles
  always @(posedge clk) begin
    if (pl_en) begin
      mem_a[pl_addr[9:2]] <= pl_data;
      mem_b[pl_addr[9:2]] <= pl_data;
    end else begin
      if (a_mem_en) begin
        if (a_mem_we) begin
          for (int b = 0; b < 4; b++)
            if (a_mem_mask[b]) mem_a[a_mem_addr[9:2]][8*b +: 8] <= a_mem_wd[8*b +: 8];
        end else a_rd_q <= mem_a[a_mem_addr[9:2]];
      end
      if (b_mem_en) begin
        if (b_mem_we) begin
          for (int b = 0; b < 4; b++)
            if (b_mem_mask[b]) mem_b[b_mem_addr[9:2]][8*b +: 8] <= b_mem_wd[8*b +: 8];
        end else b_rd_q1 <= mem_b[b_mem_addr[9:2]];
      end
    end
    b_rd_q2 <= b_rd_q1;
  end

  typedef struct {
    logic [1:0]  ireq;
    logic [1:0]  dreq;
    logic [1:0]  dwe;
    logic        en;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  mask;
    logic [3:0]  ack;   // {instr_ack[1:0], data_ack[1:0]}
  } vec_t;

  vec_t vecs [10];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rstz = 1'b0;
    instr_req = '0; data_req = '0; data_wr_en = '0;
    repeat (2) @(posedge clk);
    #1 rstz = 1'b1;
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] val);
    pl_en = 1'b1; pl_addr = addr; pl_data = val;
    step();
    pl_en = 1'b0;
  endtask

  int en_cnt;
  int ack_cyc;

  initial begin
    vecs[0] = '{2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0,        4'h0, 4'b0000};
    vecs[1] = '{2'b01, 2'b00, 2'b00, 1'b1, 1'b0, 32'h080, 32'h0,        4'h0, 4'b0100};
    vecs[2] = '{2'b10, 2'b00, 2'b00, 1'b1, 1'b0, 32'h084, 32'h0,        4'h0, 4'b1000};
    vecs[3] = '{2'b11, 2'b00, 2'b00, 1'b1, 1'b0, 32'h080, 32'h0,        4'h0, 4'b0100};
    vecs[4] = '{2'b00, 2'b10, 2'b00, 1'b1, 1'b0, 32'h044, 32'h0,        4'h0, 4'b0010};
    vecs[5] = '{2'b00, 2'b11, 2'b11, 1'b1, 1'b1, 32'h040, 32'hAAAA0000, 4'hF, 4'b0001};
    vecs[6] = '{2'b00, 2'b10, 2'b10, 1'b1, 1'b1, 32'h044, 32'hBBBB1111, 4'h3, 4'b0010};
    vecs[7] = '{2'b11, 2'b10, 2'b00, 1'b1, 1'b0, 32'h044, 32'h0,        4'h0, 4'b0010};
    vecs[8] = '{2'b01, 2'b01, 2'b01, 1'b1, 1'b1, 32'h040, 32'hAAAA0000, 4'hF, 4'b0001};
    vecs[9] = '{2'b00, 2'b01, 2'b10, 1'b1, 1'b0, 32'h040, 32'h0,        4'h0, 4'b0001};

    instr_addr[0] = 32'h080; instr_addr[1] = 32'h084;
    data_addr[0]  = 32'h040; data_addr[1]  = 32'h044;
    data_wr_data[0] = 32'hAAAA0000; data_wr_data[1] = 32'hBBBB1111;
    data_mask[0] = 4'hF; data_mask[1] = 4'h3;

    // Reset with every request raised: outputs must still be idle
    rstz = 1'b0;
    instr_req = 2'b11; data_req = 2'b11; data_wr_en = 2'b11;
    @(negedge clk);
    check("reset_a_ctrl", {a_mem_en, a_mem_we, a_mem_addr, a_mem_wd, a_mem_mask, a_instr_ack, a_data_ack}, '0);
    check("reset_a_data", {a_instr_data, a_data_rd}, '0);
    check("reset_b_ctrl", {b_mem_en, b_mem_we, b_mem_addr, b_mem_wd, b_mem_mask, b_instr_ack, b_data_ack}, '0);
    do_reset();

    preload(32'h100, 32'hDEADBEEF);
    preload(32'h104, 32'h33334444);
    preload(32'h084, 32'h5A5A0084);
    preload(32'h200, 32'hCAFEF00D);

    // Table vectors on B (fixed priority): grant outputs, then ack two cycles later
    for (int i = 0; i < 10; i++) begin
      instr_req = vecs[i].ireq; data_req = vecs[i].dreq; data_wr_en = vecs[i].dwe;
      @(negedge clk);
      check($sformatf("vec%0d_mem", i), {b_mem_en, b_mem_we, b_mem_addr, b_mem_wd, b_mem_mask},
            {vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wd, vecs[i].mask});
      step();
      instr_req = '0; data_req = '0; data_wr_en = '0;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("vec%0d_ack", i), {b_instr_ack, b_data_ack}, vecs[i].ack);
      step(); step();
    end

    // Continuous data requests from both cores
    do_reset();
    data_req = 2'b11;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("rr_a_cyc%0d", c), {a_mem_en, a_mem_addr}, {1'b1, (c % 2 == 0) ? 32'h040 : 32'h044});
      check($sformatf("rr_b_cyc%0d", c), {b_mem_en, b_mem_addr},
            (c % 3 == 2) ? {1'b0, 32'h0} : {1'b1, (c % 3 == 0) ? 32'h040 : 32'h044});
      step();
    end
    data_req = '0; step(); step(); step();
    data_req = 2'b01;
    step();
    data_req = '0; step(); step(); step();
    data_req = 2'b11;
    @(negedge clk);
    check("rr_ptr_a", a_mem_addr, 32'h044);
    check("fixed_prio_b", b_mem_addr, 32'h040);
    step();
    data_req = '0; step(); step(); step();

    // Single load on A: one grant, ack with data one cycle later
    do_reset();
    data_addr[0] = 32'h100; data_req = 2'b01;
    en_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      en_cnt += int'(a_mem_en);
      if (c == 0) check("single_grant", a_mem_addr, 32'h100);
      if (c == 1) check("single_ack", {a_data_ack, a_data_rd[0]}, {2'b01, 32'hDEADBEEF});
      else        check($sformatf("single_noack%0d", c), a_data_ack, 2'b00);
      step();
      if (c == 1) data_req = '0;
    end
    check("single_en_pulses", en_cnt, 1);

    // Starvation on A: instr forced after three consecutive losses
    do_reset();
    data_addr[0] = 32'h040; data_addr[1] = 32'h044;
    instr_req = 2'b10; data_req = 2'b11;
    ack_cyc = -1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (a_instr_ack[1] && ack_cyc < 0) begin
        ack_cyc = c;
        check("starve_data", a_instr_data[1], 32'h5A5A0084);
      end
      step();
      if (ack_cyc >= 0) instr_req = '0;
    end
    check("starve_ack_cycle", ack_cyc, 4);
    instr_req = '0; data_req = '0; step(); step(); step();

    // B with latency 2: round 0 two loads, round 1 load plus store
    for (int r = 0; r < 2; r++) begin
      do_reset();
      data_addr[0] = 32'h100;
      data_addr[1] = (r == 0) ? 32'h104 : 32'h108;
      data_wr_data[1] = 32'h77778888; data_mask[1] = 4'hF;
      data_wr_en = (r == 0) ? 2'b00 : 2'b10;
      data_req = 2'b11;
      @(negedge clk);
      check($sformatf("lat2_r%0d_g0", r), {b_mem_en, b_mem_we, b_mem_addr}, {1'b1, 1'b0, 32'h100});
      step();
      @(negedge clk);
      check($sformatf("lat2_r%0d_g1", r), {b_mem_en, b_mem_we, b_mem_addr},
            {1'b1, (r == 1), data_addr[1]});
      step();
      @(negedge clk);
      check($sformatf("lat2_r%0d_ack0", r), {b_data_ack, b_data_rd[0], b_data_rd[1]},
            {2'b01, 32'hDEADBEEF, 32'h0});
      step();
      data_req = 2'b10;
      @(negedge clk);
      check($sformatf("lat2_r%0d_ack1", r), {b_data_ack, b_data_rd[1]},
            {2'b10, (r == 0) ? 32'h33334444 : 32'h0});
      step();
      data_req = '0;
      @(negedge clk);
      check($sformatf("lat2_r%0d_idle", r), {b_mem_en, b_data_ack}, '0);
    end
    data_wr_data[1] = 32'hBBBB1111; data_mask[1] = 4'h3;

    // Partial store then load to the same address on A
    do_reset();
    data_addr[0] = 32'h200; data_wr_data[0] = 32'h12345678; data_mask[0] = 4'b0011;
    data_wr_en = 2'b01; data_req = 2'b01;
    @(negedge clk);
    check("sw_grant", {a_mem_en, a_mem_we, a_mem_addr, a_mem_wd, a_mem_mask},
          {1'b1, 1'b1, 32'h200, 32'h12345678, 4'b0011});
    step();
    @(negedge clk);
    check("sw_ack", {a_data_ack, a_data_rd[0]}, {2'b01, 32'h0});
    step();
    data_wr_en = '0;
    @(negedge clk);
    check("lw_grant", {a_mem_en, a_mem_we, a_mem_addr}, {1'b1, 1'b0, 32'h200});
    step();
    @(negedge clk);
    check("lw_ack", {a_data_ack, a_data_rd[0]}, {2'b01, 32'hCAFE5678});
    step();
    data_req = '0;

    // Reset while B holds an in-flight read tag
    do_reset();
    data_addr[0] = 32'h100; data_req = 2'b01;
    @(negedge clk);
    check("rst_pre_grant", b_mem_en, 1'b1);
    step();
    rstz = 1'b0;
    @(negedge clk);
    check("rst_outputs_b", {b_mem_en, b_mem_addr, b_instr_ack, b_data_ack, b_data_rd}, '0);
    check("rst_outputs_a", {a_mem_en, a_mem_addr, a_instr_ack, a_data_ack, a_data_rd}, '0);
    step();
    data_req = '0; rstz = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rst_noack%0d", c), {b_data_ack, a_data_ack, b_mem_en}, '0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
